// File: rtl/ik_swift_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ik_swift_pkg
// Description : Shared constants for the ik_swift Avalon bridge: operand word
//               width, word-address map of the host register space, and the
//               run-sequencer state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package ik_swift_pkg;

    // Fixed-point width of every core operand and result word
    localparam int WORD_W = 27;

    // Word-address map of the host register space
    localparam logic [8:0] Z_BASE    = 9'd0;
    localparam logic [8:0] JT_ADDR   = 9'd3;
    localparam logic [8:0] DH_BASE   = 9'd4;
    localparam logic [8:0] CTRL_ADDR = 9'd28;
    localparam logic [8:0] JAC_BASE  = 9'd64;
    localparam logic [8:0] JJT_BASE  = 9'd128;
    localparam logic [8:0] LT_BASE   = 9'd192;
    localparam logic [8:0] INV_BASE  = 9'd256;

    // Word counts of each region
    localparam int N_Z   = 3;
    localparam int N_DH  = 24;
    localparam int N_RES = 36;

    // Run sequencer states
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RESET = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } ik_state_e;

endpackage
`default_nettype wire

// File: rtl/ik_swift_result_mux.sv
`default_nettype none
// ============================================================================
// Module      : ik_swift_result_mux
// Description : Combinational select of one word out of a 6x6 result matrix,
//               sign-extended to the 32-bit bus. Indices past the last word
//               (36..63) return zero.
// Ports       : mat  - packed [5:0][5:0][WORD_W-1:0] result matrix
//               idx  - linear word index, 6*row + col
//               word - selected word, sign-extended to 32 bits
// Revision    : 1.0 - initial release
// ============================================================================
module ik_swift_result_mux
    import ik_swift_pkg::*;
(
    input  logic [5:0][5:0][WORD_W-1:0] mat,
    input  logic [5:0]                  idx,
    output logic [31:0]                 word
);

    // A packed [5:0][5:0] matrix laid flat puts [r][c] at 6*r+c, which is
    // exactly the offset within the address region.
    logic [N_RES-1:0][WORD_W-1:0] flat;
    logic [WORD_W-1:0]            sel;

    always_comb begin
        flat = mat;
        sel  = '0;
        if (idx < 6'(N_RES)) begin
            sel = flat[idx];
        end
        word = {{(32-WORD_W){sel[WORD_W-1]}}, sel};
    end

endmodule
`default_nettype wire

// File: rtl/ik_swift_avalon_bridge.sv
`default_nettype none
// ============================================================================
// Module      : ik_swift_avalon_bridge
// Description : Avalon-MM slave that loads ik_swift core parameters, sequences
//               the core's ik_rst/ik_en on a start command, and exposes the
//               four 6x6 result matrices as word-addressable read space.
// Ports       : clk, rst (async, active-high)
//               chipselect/write/read/address/writedata/readdata - Avalon slave
//               irq          - level interrupt, mirrors done
//               ik_en/ik_rst - core enable / core reset
//               z, joint_type, dh_param - parameter outputs to the core
//               jacobian_matrix, jjt_bias, lt, inverse - core results
// Revision    : 1.0 - initial release
// ============================================================================
module ik_swift_avalon_bridge
    import ik_swift_pkg::*;
#(
    parameter int RST_CYCLES = 2,
    parameter int RUN_CYCLES = 64
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        chipselect,
    input  logic                        write,
    input  logic                        read,
    input  logic [8:0]                  address,
    input  logic [31:0]                 writedata,
    output logic [31:0]                 readdata,
    output logic                        irq,
    output logic                        ik_en,
    output logic                        ik_rst,
    output logic [2:0][WORD_W-1:0]      z,
    output logic [5:0]                  joint_type,
    output logic [5:0][3:0][WORD_W-1:0] dh_param,
    input  logic [5:0][5:0][WORD_W-1:0] jacobian_matrix,
    input  logic [5:0][5:0][WORD_W-1:0] jjt_bias,
    input  logic [5:0][5:0][WORD_W-1:0] lt,
    input  logic [5:0][5:0][WORD_W-1:0] inverse
);

    localparam int CNT_MAX = (RUN_CYCLES > RST_CYCLES) ? RUN_CYCLES : RST_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    ik_state_e                  state_q, state_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic                       ik_rst_q, ik_rst_d;
    logic                       ik_en_q, ik_en_d;
    logic                       done_q, done_d;
    logic [31:0]                readdata_q, readdata_d;
    logic [N_Z-1:0][WORD_W-1:0] z_q, z_d;
    logic [5:0]                 jt_q, jt_d;
    logic [N_DH-1:0][WORD_W-1:0] dh_q, dh_d;

    logic                       busy;
    logic                       start;
    logic [4:0]                 dh_off;
    logic [3:0][5:0][5:0][WORD_W-1:0] res_all;
    logic [3:0][31:0]           res_word;
    logic                       unused_wdata;

    assign busy         = (state_q == S_RESET) || (state_q == S_RUN);
    assign dh_off       = address[4:0] - 5'd4;
    assign unused_wdata = &{1'b0, writedata[31:WORD_W]};

    // Region order matches address[8:6] - 1
    assign res_all = {inverse, lt, jjt_bias, jacobian_matrix};

    for (genvar g = 0; g < 4; g++) begin : g_res_mux
        ik_swift_result_mux u_mux (
            .mat  (res_all[g]),
            .idx  (address[5:0]),
            .word (res_word[g])
        );
    end

    // Parameter writes and start decode; everything is locked while busy
    always_comb begin
        z_d   = z_q;
        jt_d  = jt_q;
        dh_d  = dh_q;
        start = 1'b0;
        if (chipselect && write && !busy) begin
            if (address < JT_ADDR) begin
                z_d[address[1:0]] = writedata[WORD_W-1:0];
            end else if (address == JT_ADDR) begin
                jt_d = writedata[5:0];
            end else if ((address >= DH_BASE) && (address < CTRL_ADDR)) begin
                dh_d[dh_off] = writedata[WORD_W-1:0];
            end else if (address == CTRL_ADDR) begin
                start = writedata[0];
            end
        end
    end

    // Read path; sources are all current register values, so a same-cycle
    // write to the read address returns the old contents
    always_comb begin
        readdata_d = readdata_q;
        if (chipselect && read) begin
            readdata_d = '0;
            case (address[8:6])
                3'd0: begin
                    if (address < JT_ADDR) begin
                        readdata_d = {{(32-WORD_W){1'b0}}, z_q[address[1:0]]};
                    end else if (address == JT_ADDR) begin
                        readdata_d = {26'd0, jt_q};
                    end else if ((address >= DH_BASE) && (address < CTRL_ADDR)) begin
                        readdata_d = {{(32-WORD_W){1'b0}}, dh_q[dh_off]};
                    end else if (address == CTRL_ADDR) begin
                        readdata_d = {30'd0, done_q, busy};
                    end
                end
                3'd1:    readdata_d = res_word[0];
                3'd2:    readdata_d = res_word[1];
                3'd3:    readdata_d = res_word[2];
                3'd4:    readdata_d = res_word[3];
                default: readdata_d = '0;
            endcase
        end
    end

    // Run sequencer; core controls are decoded from the next state so they
    // change on the same edge as the state
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_RESET;
                    cnt_d   = CNT_W'(RST_CYCLES - 1);
                end
            end
            S_RESET: begin
                if (cnt_q == '0) begin
                    state_d = S_RUN;
                    cnt_d   = CNT_W'(RUN_CYCLES - 1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_RUN: begin
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
        ik_rst_d = (state_d == S_RESET);
        ik_en_d  = (state_d == S_RUN);
        done_d   = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            ik_rst_q   <= 1'b1;
            ik_en_q    <= 1'b0;
            done_q     <= 1'b0;
            readdata_q <= '0;
            z_q        <= '0;
            jt_q       <= '0;
            dh_q       <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ik_rst_q   <= ik_rst_d;
            ik_en_q    <= ik_en_d;
            done_q     <= done_d;
            readdata_q <= readdata_d;
            z_q        <= z_d;
            jt_q       <= jt_d;
            dh_q       <= dh_d;
        end
    end

    assign readdata   = readdata_q;
    assign irq        = done_q;
    assign ik_en      = ik_en_q;
    assign ik_rst     = ik_rst_q;
    assign z          = z_q;
    assign joint_type = jt_q;
    assign dh_param   = dh_q;

endmodule
`default_nettype wire

// File: doc/ik_swift_avalon_bridge.md
# ik_swift_avalon_bridge

Host-side bus endpoint that drives the ik_swift solver core from the Avalon-MM interconnect. It accepts parameter writes and assembles z, joint_type and dh_param. On a start command it sequences the core's rst/en, then exposes jacobian_matrix, jjt_bias, lt and inverse as word-addressable read space. It is the host-facing counterpart of the ik_swift core's input/output bundle and sits between the HPS lightweight bridge and the core.

## Interface
- WORD_W, 27: fixed-point word width of every core operand/result
- RST_CYCLES, 2: cycles ik_rst is held high at the start of a run (≥1)
- RUN_CYCLES, 64: cycles ik_en is held high before done is flagged (≥1)

- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- chipselect  in  1  Avalon slave select
- write  in  1  write strobe, qualified by chipselect
- read  in  1  read strobe, qualified by chipselect
- address  in  9  word address
- writedata  in  32  write data
- readdata  out  32  read data, valid the cycle after read
- irq  out  1  level interrupt, equals done
- ik_en  out  1  core enable
- ik_rst  out  1  core reset
- z  out  3×WORD_W  base joint axis, packed [2:0][WORD_W-1:0]
- joint_type  out  6  joint type bit vector
- dh_param  out  6×4×WORD_W  DH parameters, packed [5:0][3:0][WORD_W-1:0]
- jacobian_matrix, jjt_bias, lt, inverse  in  6×6×WORD_W each  core results, packed [5:0][5:0][WORD_W-1:0]

## Operation
- Address map (words):
  - 0–2: z[i]
  - 3: joint_type, bits 5:0
  - 4–27: dh_param[j][p] at 4+4j+p
  - 28: control/status
  - 64–99: jacobian_matrix[r][c] at 64+6r+c
  - 128–163: jjt_bias at 128+6r+c
  - 192–227: lt at 192+6r+c
  - 256–291: inverse at 256+6r+c
- Parameter writes store writedata[WORD_W-1:0]; upper bits are discarded.
- Parameter writes are ignored while busy (RESET or RUN).
- Parameter registers are readable at the same addresses.
- Result reads return the core word sign-extended from WORD_W to 32 bits.
- Unmapped reads return 0. Unmapped writes are ignored.
- Control write bit0 = start. Status read: bit0 busy, bit1 done, others 0.
- FSM: IDLE → RESET → RUN → DONE.
  - IDLE: on start, go to RESET and load the counter.
  - RESET: ik_rst=1 for RST_CYCLES cycles, then go to RUN.
  - RUN: ik_en=1 for RUN_CYCLES cycles, then go to DONE.
  - DONE: done=1, ik_en=0. Results are held by the idle core.
  - Start in DONE clears done and goes to RESET.
- Start while busy is ignored.
- Status reads do not clear done.

## Timing
- Reset values:
  - readdata, irq, ik_en: 0
  - z, joint_type, dh_param: all 0
  - ik_rst: 1
  - FSM state: IDLE, with done=0
- ik_rst falls on the first clk edge after rst deasserts.
- All outputs are registered.
- Read latency is fixed at 1 cycle; no waitrequest.
- Start write at edge N: ik_rst=1 during cycles N+1…N+RST_CYCLES, then ik_en=1 for exactly RUN_CYCLES cycles.
- done/irq rise the cycle after ik_en falls.
- Total cycles from the start edge to done: RST_CYCLES+RUN_CYCLES+1.
- Simultaneous read and write to the same address: readdata returns the old value.
- rst mid-run: ik_en drops and ik_rst rises immediately (asynchronously); parameters clear; the run is abandoned.
- Write and read asserted together are both honored.

## Structure
- Package ik_swift_pkg holds:
  - WORD_W
  - address-region base constants (Z_BASE, JT_ADDR, DH_BASE, CTRL_ADDR, JAC_BASE, JJT_BASE, LT_BASE, INV_BASE)
  - the FSM state enum
- One sub-module, ik_swift_result_mux: combinational 6×6 word select plus sign extension, instanced once per result region; the bridge registers the final 4:1 select.

## Test plan
- Reset: assert rst mid-cycle → ik_rst=1, ik_en=0, readdata=0, status=0 with no clock edge; one edge after release, ik_rst=0.
- Load/readback: write 0x7FFFFFF to addr 0, 0x15 to 3, 0x1234567 to 27 → dh_param[5][3]=0x1234567 and joint_type=6'h15; reads of those addresses return the same values.
- Run sequencing (RST_CYCLES=2, RUN_CYCLES=64): write 1 to 28 → ik_rst high for exactly 2 cycles, ik_en high for exactly 64 cycles, status=1 throughout, irq=1 on cycle 67.
- Busy protection: during RUN write 5 to addr 0 and 1 to addr 28 → z[0] unchanged, ik_en pulse length unchanged.
- Result read: drive inverse[2][3]=27'h4000000 → read addr 256+15 returns 0xFC000000; drive jacobian[0][0]=27'h0000001 → read 64 returns 1; read addr 40 returns 0.
- Restart: in DONE write start → done clears next cycle and a new full ik_rst/ik_en sequence follows; asserting rst during that RUN → ik_en=0 immediately, state IDLE.
